iterative_shifter: RTL and testbench

- Multi-cycle parametrised shifter for the execute stage; replaces chains of fixed-distance shift stages.
- Shifts WIDTH-bit operand by runtime amount, at most STEP bit positions per clock.
- Modes: logical left, logical right, arithmetic right, rotate right.
- Valid/ready handshake on both sides so the pipeline can stall on it like the multiplier/divider.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shift_step.sv | 57 +++++
 rtl/iterative_shifter.sv | 122 ++++++++++++
 tb/tb_iterative_shifter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants for the iterative shifter: mode codes and FSM state encoding.
package shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts by 0..STEP positions using a chain of
// conditional fixed-distance stages (1, 2, 4, ... STEP), each enabled by one
// bit of the amount.
module shift_step
    import shifter_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 4,
    localparam int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] res_o
);

    logic [AMT_W:0][WIDTH-1:0] v;

    assign v[0] = val_i;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int D = 1 << k;
        logic [WIDTH-1:0] sh;

        if (D < WIDTH) begin : g_part
            // Fixed shift by D with mode-dependent fill.
            always_comb begin
                sh = v[k];
                case (mode_i)
                    MODE_SLL: sh = {v[k][WIDTH-1-D:0], {D{1'b0}}};
                    MODE_SRL: sh = {{D{1'b0}}, v[k][WIDTH-1:D]};
                    MODE_SRA: sh = {{D{v[k][WIDTH-1]}}, v[k][WIDTH-1:D]};
                    MODE_ROR: sh = {v[k][D-1:0], v[k][WIDTH-1:D]};
                    default:  sh = v[k];
                endcase
            end
        end else begin : g_full
            // Stage distance equals the width (only when STEP == WIDTH):
            // everything shifts out, rotate is the identity.
            always_comb begin
                sh = v[k];
                case (mode_i)
                    MODE_SLL: sh = '0;
                    MODE_SRL: sh = '0;
                    MODE_SRA: sh = {WIDTH{v[k][WIDTH-1]}};
                    MODE_ROR: sh = v[k];
                    default:  sh = v[k];
                endcase
            end
        end

        assign v[k+1] = amt_i[k] ? sh : v[k];
    end

    assign res_o = v[AMT_W];

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: accepts one request in IDLE, shifts at most STEP bit
// positions per clock in SHIFT, then presents the result in DONE until the
// consumer takes it.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);

    localparam int AMT_W = $clog2(STEP) + 1;
    // One extra bit so STEP itself is representable even when STEP == WIDTH.
    localparam int CW    = SHAMT_W + 1;

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [SHAMT_W-1:0]   rem_q;
    logic [1:0]           mode_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [CW-1:0]        rem_ext;
    logic [CW-1:0]        step_c;
    logic [CW-1:0]        d_wide;
    logic [AMT_W-1:0]     amt;
    logic                 last_step;
    logic [SHAMT_W-1:0]   rem_d;
    logic [WIDTH-1:0]     acc_d;

    // Per-cycle distance d = min(rem, STEP); d never exceeds rem, so rem_d cannot wrap.
    always_comb begin
        rem_ext   = {1'b0, rem_q};
        step_c    = CW'(STEP);
        last_step = (rem_ext <= step_c);
        d_wide    = last_step ? rem_ext : step_c;
        amt       = AMT_W'(d_wide);
        rem_d     = rem_q - SHAMT_W'(d_wide);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .val_i  (acc_q),
        .amt_i  (amt),
        .mode_i (mode_q),
        .res_o  (acc_d)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            mode_q      <= MODE_SLL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_q      <= data_in;
                        rem_q      <= shamt;
                        mode_q     <= mode;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (shamt == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (last_step) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = acc_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: three builds (STEP=4, STEP=1, STEP=32) share the
// data inputs and each has its own handshake; results are compared with a
// plain-arithmetic shift model and a ceil-division latency model.
module tb_iterative_shifter;

    logic        clock;
    logic        reset;
    logic [31:0] din;
    logic [4:0]  sh;
    logic [1:0]  md;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  bz;
    logic [31:0] dout [3];

    int passed;
    int total;

    iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in(din), .shamt(sh), .mode(md), .out_valid(ov[0]),
        .out_ready(ordy[0]), .data_out(dout[0]), .busy(bz[0]));

    iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in(din), .shamt(sh), .mode(md), .out_valid(ov[1]),
        .out_ready(ordy[1]), .data_out(dout[1]), .busy(bz[1]));

    iterative_shifter #(.WIDTH(32), .STEP(32)) dut32 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_in(din), .shamt(sh), .mode(md), .out_valid(ov[2]),
        .out_ready(ordy[2]), .data_out(dout[2]), .busy(bz[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic [1:0] m);
        case (m)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return 32'($signed(d) >>> a);
            default: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
        endcase
    endfunction

    function automatic int step_of(input int which);
        case (which)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    task automatic run_op(input int which, input logic [31:0] d, input int a,
                          input logic [1:0] m, input int stall, input string tag);
        logic [31:0] exp;
        int lat_exp;
        int edges;
        exp     = ref_shift(d, a, m);
        lat_exp = 1 + (a + step_of(which) - 1) / step_of(which);
        @(negedge clock);
        total++;
        if (ir[which] !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", tag, ir[which]);
        else passed++;
        din = d; sh = 5'(a); md = m;
        iv[which]   = 1'b1;
        ordy[which] = (stall == 0);
        @(posedge clock);
        @(negedge clock);
        iv[which] = 1'b0;
        // Scramble inputs after the accept edge; the DUT must ignore them.
        din = $urandom; sh = 5'($urandom); md = 2'($urandom);
        edges = 1;
        while (ov[which] !== 1'b1 && edges < 200) begin
            @(negedge clock);
            edges++;
        end
        total++;
        if (ov[which] !== 1'b1) $display("FAIL %s timeout: out_valid got %b want 1", tag, ov[which]);
        else passed++;
        total++;
        if (edges != lat_exp) $display("FAIL %s latency: got %0d want %0d", tag, edges, lat_exp);
        else passed++;
        total++;
        if (dout[which] !== exp) $display("FAIL %s data: got %h want %h", tag, dout[which], exp);
        else passed++;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            total++;
            if (dout[which] !== exp || ir[which] !== 1'b0 || ov[which] !== 1'b1)
                $display("FAIL %s hold: data %h ir %b ov %b want %h 0 1", tag, dout[which], ir[which], ov[which], exp);
            else passed++;
        end
        ordy[which] = 1'b1;
        @(negedge clock);
        total++;
        if (ov[which] !== 1'b0 || ir[which] !== 1'b1 || bz[which] !== 1'b0)
            $display("FAIL %s release: ov %b ir %b busy %b want 0 1 0", tag, ov[which], ir[which], bz[which]);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iv = '0; ordy = '1; din = '0; sh = '0; md = '0;
        repeat (3) @(negedge clock);
        for (int w = 0; w < 3; w++) begin
            total++;
            if (ir[w] !== 1'b1 || ov[w] !== 1'b0 || bz[w] !== 1'b0 || dout[w] !== 32'h0)
                $display("FAIL reset[%0d]: ir %b ov %b busy %b data %h want 1 0 0 0", w, ir[w], ov[w], bz[w], dout[w]);
            else passed++;
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_op(0, 32'h80000000, 4,  2'b10, 0, "sra_4");
        run_op(0, 32'h80000000, 31, 2'b01, 0, "srl_31");
        run_op(0, 32'h80000000, 31, 2'b10, 0, "sra_31");
        run_op(0, 32'h00000001, 31, 2'b00, 0, "sll_31");
        run_op(0, 32'h12345678, 0,  2'b00, 0, "sll_0");
        run_op(0, 32'h00000001, 1,  2'b11, 0, "ror_1");
        run_op(0, 32'h0000000F, 5,  2'b11, 0, "ror_5");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(0, $urandom, int'($urandom_range(0, 31)), 2'($urandom),
                   int'($urandom_range(0, 2)), "rand4");
    endtask

    task automatic test_backpressure();
        int edges;
        @(negedge clock);
        din = 32'hFFFF0000; sh = 5'd8; md = 2'b01;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        // Next request held on the bus while the first one is in flight.
        din = 32'hDEADBEEF; sh = 5'd4; md = 2'b00;
        edges = 1;
        while (ov[0] !== 1'b1 && edges < 50) begin
            @(negedge clock);
            edges++;
        end
        total++;
        if (edges != 3 || ov[0] !== 1'b1) $display("FAIL bp_latency: got %0d ov %b want 3 1", edges, ov[0]);
        else passed++;
        for (int s = 0; s < 5; s++) begin
            total++;
            if (dout[0] !== 32'h00FFFF00 || ir[0] !== 1'b0 || ov[0] !== 1'b1 || bz[0] !== 1'b1)
                $display("FAIL bp_hold: data %h ir %b ov %b busy %b want 00ffff00 0 1 1", dout[0], ir[0], ov[0], bz[0]);
            else passed++;
            @(negedge clock);
        end
        ordy[0] = 1'b1;
        @(negedge clock);
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0)
            $display("FAIL bp_idle: ov %b ir %b busy %b want 0 1 0", ov[0], ir[0], bz[0]);
        else passed++;
        @(negedge clock);
        iv[0] = 1'b0;
        total++;
        if (bz[0] !== 1'b1 || ir[0] !== 1'b0)
            $display("FAIL bp_accept: busy %b ir %b want 1 0", bz[0], ir[0]);
        else passed++;
        edges = 1;
        while (ov[0] !== 1'b1 && edges < 50) begin
            @(negedge clock);
            edges++;
        end
        total++;
        if (ov[0] !== 1'b1 || dout[0] !== 32'hEADBEEF0)
            $display("FAIL bp_second: ov %b data %h want 1 eadbeef0", ov[0], dout[0]);
        else passed++;
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clock);
        din = 32'hA5A5A5A5; sh = 5'd20; md = 2'b01;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iv[0] = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0 || dout[0] !== 32'h0)
            $display("FAIL async_reset: ov %b ir %b busy %b data %h want 0 1 0 0", ov[0], ir[0], bz[0], dout[0]);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (ov[0] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL post_reset_pulse: out_valid cycles %0d want 0", seen);
        else passed++;
    endtask

    task automatic test_step1();
        run_op(1, 32'hC0000000, 3, 2'b10, 0, "s1_sra3");
        for (int i = 0; i < 4; i++)
            run_op(1, $urandom, int'($urandom_range(0, 31)), 2'($urandom), 1, "s1_rand");
    endtask

    task automatic test_step32();
        run_op(2, 32'h80000000, 31, 2'b10, 0, "s32_sra31");
        for (int i = 0; i < 6; i++)
            run_op(2, $urandom, int'($urandom_range(1, 31)), 2'($urandom), 0, "s32_rand");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_async_reset();
        test_step1();
        test_step32();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
